// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
//   - ALU opcode encodings (OP_AND .. OP_MUL, OP_ILLEGAL)
//   - ALU input-select one-hot encodings (persist / load / clear)
//   - sequencer FSM state encoding (2-bit)
//   - command record stored in the FIFO
//   - op_to_outsel(): opcode -> one-hot ALU output select
package alu_seq_pkg;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_NOT     = 3'd2;
    localparam logic [2:0] OP_XOR     = 3'd3;
    localparam logic [2:0] OP_ADD     = 3'd4;
    localparam logic [2:0] OP_SUB     = 3'd5;
    localparam logic [2:0] OP_MUL     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_CLEAR   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
    } cmd_t;

    // Bit 6 selects AND, bit 0 selects MUL; the illegal opcode maps to all-zero.
    function automatic logic [6:0] op_to_outsel(input logic [2:0] op);
        return 7'b1000000 >> op;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: host-side command and response channels.
//   cmd_valid/cmd_ready + cmd_op, cmd_a, cmd_b, cmd_chain : command in
//   res_valid/res_ready + res_data, res_err               : response out
// Modports: master = host, slave = sequencer.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. Once valid is raised the payload is
// held stable and valid stays high until that transfer happens; ready may be
// raised or lowered freely and never depends on valid.
interface alu_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// alu_cmd_fifo: synchronous FIFO with registered full/empty flags.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   i_push    : write request, ignored while full
//   i_wdata   : write data
//   i_pop     : read request, ignored while empty
//   o_rdata   : head entry (valid while !o_empty)
//   o_full    : registered full flag
//   o_empty   : registered empty flag
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    always_comb begin
        w_push      = i_push && !r_full;
        w_pop       = i_pop && !r_empty;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are registered from the next count, so a pop while full frees
    // the slot but o_full only drops on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands and issues them one at a time to
// the 8-bit accumulator ALU, then returns result/overflow on a response port.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   host          : alu_cmd_sequencer_if.slave (command in, response out)
//   alu_num1/2    : ALU operands (held between issues)
//   alu_in_sel    : one-hot 100 persist / 010 load / 001 clear
//   alu_out_sel   : one-hot operation select, bit6 AND .. bit0 MUL
//   alu_result    : ALU output value
//   alu_ovf       : ALU multiply overflow
//   stat_cmds/errs: response / error-response counters (ALU_SEQ_STATS_EN only)
//   o_dbg_state   : current FSM state
// Optional feature macro: ALU_SEQ_STATS_EN adds saturating 16-bit counters.
// ALU_LAT must be at least 1.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_cmd_sequencer_if.slave host,
    output logic [7:0]  alu_num1,
    output logic [7:0]  alu_num2,
    output logic [2:0]  alu_in_sel,
    output logic [6:0]  alu_out_sel,
    input  logic [7:0]  alu_result,
    input  logic        alu_ovf,
`ifdef ALU_SEQ_STATS_EN
    output logic [15:0] stat_cmds,
    output logic [15:0] stat_errs,
`endif
    output state_t      o_dbg_state
);

    localparam int CMD_W = $bits(cmd_t);
    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic             r_chain;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [7:0]       r_num1;
    logic [7:0]       r_num2;
    logic [6:0]       r_out_sel;
    logic [7:0]       r_res_data;
    logic             r_res_err;

    logic [CMD_W-1:0] w_cmd_in;
    logic [CMD_W-1:0] w_head_bits;
    cmd_t             w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_capture;
    logic             w_res_hs;

    assign w_cmd_in = {host.cmd_op, host.cmd_a, host.cmd_b, host.cmd_chain};
    assign w_head   = cmd_t'(w_head_bits);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (host.cmd_valid),
        .i_wdata (w_cmd_in),
        .i_pop   (w_pop),
        .o_rdata (w_head_bits),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    // Illegal opcodes never touch the ALU.
                    w_state_nxt = (w_head.op == OP_ILLEGAL) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                // The counter is loaded with ALU_LAT; the capture happens on
                // the cycle whose decrement would take it to zero, so WAIT
                // lasts exactly ALU_LAT cycles.
                if (r_lat_cnt <= LAT_W'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (host.res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_ADD;
            r_chain    <= 1'b0;
            r_lat_cnt  <= '0;
            r_num1     <= 8'h00;
            r_num2     <= 8'h00;
            r_out_sel  <= op_to_outsel(OP_ADD);
            r_res_data <= 8'h00;
            r_res_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_op    <= w_head.op;
                r_chain <= w_head.chain;
                if (w_head.op == OP_ILLEGAL) begin
                    r_res_data <= 8'h00;
                    r_res_err  <= 1'b1;
                end else begin
                    // Operands and select are registered here so they are
                    // presented during ISSUE and simply held afterwards.
                    r_num1    <= w_head.a;
                    r_num2    <= w_head.b;
                    r_out_sel <= op_to_outsel(w_head.op);
                end
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= LAT_W'(ALU_LAT);
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
            if (w_capture) begin
                r_res_data <= alu_result;
                r_res_err  <= alu_ovf && (r_op == OP_MUL);
            end
        end
    end

    // Clear is driven straight from rst so the accumulator empties in the
    // reset cycle itself; otherwise the accumulator holds except on a
    // non-chained issue.
    always_comb begin
        alu_in_sel = IN_SEL_PERSIST;
        if (rst) begin
            alu_in_sel = IN_SEL_CLEAR;
        end else if ((r_state == ST_ISSUE) && !r_chain) begin
            alu_in_sel = IN_SEL_LOAD;
        end
    end

    assign alu_num1    = r_num1;
    assign alu_num2    = r_num2;
    assign alu_out_sel = r_out_sel;

    assign w_res_hs       = (r_state == ST_RESP) && host.res_ready;
    assign host.cmd_ready = !w_fifo_full;
    assign host.res_valid = (r_state == ST_RESP);
    assign host.res_data  = r_res_data;
    assign host.res_err   = r_res_err;
    assign o_dbg_state    = r_state;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_stat_cmds;
    logic [15:0] r_stat_errs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cmds <= 16'h0000;
            r_stat_errs <= 16'h0000;
        end else if (w_res_hs) begin
            if (r_stat_cmds != 16'hFFFF) r_stat_cmds <= r_stat_cmds + 16'd1;
            if (r_res_err && (r_stat_errs != 16'hFFFF)) r_stat_errs <= r_stat_errs + 16'd1;
        end
    end

    assign stat_cmds = r_stat_cmds;
    assign stat_errs = r_stat_errs;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_res_hs;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed cases with hand-computed results,
// then randomized traffic checked every cycle against a queue-based model.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if hif();

  logic [7:0] alu_num1, alu_num2, alu_result;
  logic [2:0] alu_in_sel;
  logic [6:0] alu_out_sel;
  logic       alu_ovf;
  state_t     dbg_state;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_cmds, stat_errs;
`endif

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (hif),
    .alu_num1    (alu_num1),
    .alu_num2    (alu_num2),
    .alu_in_sel  (alu_in_sel),
    .alu_out_sel (alu_out_sel),
    .alu_result  (alu_result),
    .alu_ovf     (alu_ovf),
`ifdef ALU_SEQ_STATS_EN
    .stat_cmds   (stat_cmds),
    .stat_errs   (stat_errs),
`endif
    .o_dbg_state (dbg_state)
  );

  // ---------------- ALU stub (one operand register stage) ----------------
  logic [7:0] alu_acc;
  logic       alu_ovf_q;

  function automatic logic [8:0] alu_fn(input logic [6:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (sel)
      7'b1000000: return {1'b0, a & b};
      7'b0100000: return {1'b0, a | b};
      7'b0010000: return {1'b0, ~a};
      7'b0001000: return {1'b0, a ^ b};
      7'b0000100: return {1'b0, 8'(a + b)};
      7'b0000010: return {1'b0, 8'(a - b)};
      7'b0000001: return {(p > 16'd255), p[7:0]};
      default:    return 9'h000;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [8:0] r;
    if (alu_in_sel == IN_SEL_CLEAR) begin
      alu_acc   <= 8'h00;
      alu_ovf_q <= 1'b0;
    end else if (dbg_state == ST_ISSUE) begin
      r = alu_fn(alu_out_sel, (alu_in_sel == IN_SEL_LOAD) ? alu_num1 : alu_acc, alu_num2);
      alu_acc   <= r[7:0];
      alu_ovf_q <= r[8];
    end
  end
  assign alu_result = alu_acc;
  assign alu_ovf    = alu_ovf_q;

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Result of one command from the opcode table; {err, data}.
  function automatic logic [8:0] model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~a};
      3'd3: return {1'b0, a ^ b};
      3'd4: return {1'b0, 8'(a + b)};
      3'd5: return {1'b0, 8'(a - b)};
      3'd6: return {(p > 16'd255), p[7:0]};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  logic [8:0]  exp_q[$];   // expected responses {err, data}
  logic [25:0] iss_q[$];   // expected issues {in_sel, out_sel, num1, num2}
  logic [7:0]  model_acc;
  bit          was_rst = 1'b0;
  bit          prev_stall = 1'b0;
  logic [8:0]  prev_resp;
  int          hs_cnt = 0;
  int          err_cnt = 0;

  always @(negedge clk) begin
    logic [8:0]  r;
    logic [25:0] e;
    logic [7:0]  a_eff;
    if (rst) begin
      chk("in_sel_during_rst", alu_in_sel, IN_SEL_CLEAR);
      exp_q.delete();
      iss_q.delete();
      model_acc  = 8'h00;
      was_rst    = 1'b1;
      prev_stall = 1'b0;
      hs_cnt     = 0;
      err_cnt    = 0;
    end else begin
      if (was_rst) begin
        chk("rst_res_valid", hif.res_valid, 1'b0);
        chk("rst_res_data", hif.res_data, 8'h00);
        chk("rst_res_err", hif.res_err, 1'b0);
        chk("rst_num1", alu_num1, 8'h00);
        chk("rst_num2", alu_num2, 8'h00);
        chk("rst_out_sel", alu_out_sel, 7'b0000100);
        chk("rst_cmd_ready", hif.cmd_ready, 1'b1);
        was_rst = 1'b0;
      end
      // issue side
      if (dbg_state == ST_ISSUE) begin
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          e = iss_q.pop_front();
          chk("issue_in_sel", alu_in_sel, e[25:23]);
          chk("issue_out_sel", alu_out_sel, e[22:16]);
          chk("issue_num1", alu_num1, e[15:8]);
          chk("issue_num2", alu_num2, e[7:0]);
        end
      end else begin
        chk("idle_in_sel", alu_in_sel, IN_SEL_PERSIST);
      end
      // response side
      if (prev_stall) begin
        chk("stall_valid", hif.res_valid, 1'b1);
        chk("stall_data", {hif.res_err, hif.res_data}, prev_resp);
      end
      if (hif.res_valid && hif.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("resp_data", hif.res_data, r[7:0]);
          chk("resp_err", hif.res_err, r[8]);
          hs_cnt++;
          if (r[8]) err_cnt++;
        end
      end
      prev_stall = hif.res_valid && !hif.res_ready;
      prev_resp  = {hif.res_err, hif.res_data};
      // command acceptance feeds the model in order
      if (hif.cmd_valid && hif.cmd_ready) begin
        a_eff = hif.cmd_chain ? model_acc : hif.cmd_a;
        r = model_op(hif.cmd_op, a_eff, hif.cmd_b);
        exp_q.push_back(r);
        if (hif.cmd_op != 3'd7) begin
          model_acc = r[7:0];
          iss_q.push_back({hif.cmd_chain ? 3'b100 : 3'b010, 7'(7'b1000000 >> hif.cmd_op),
                           hif.cmd_a, hif.cmd_b});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic chain, input int bound, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = op;
    hif.cmd_a     = a;
    hif.cmd_b     = b;
    hif.cmd_chain = chain;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      ok = hif.cmd_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    hif.cmd_valid = 1'b0;
  endtask

  // One command from an idle sequencer, with hand-computed expectations.
  task automatic run_one(input string name, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic chain, input logic [7:0] ed,
                         input logic ee, input logic [2:0] e_in, input logic [6:0] e_out);
    bit ok, got, saw;
    int lat;
    logic [2:0] s_in;
    logic [6:0] s_out;
    got = 0; saw = 0; lat = 0; s_in = '0; s_out = '0;
    push_cmd(op, a, b, chain, 10, ok);
    chk({name, "_accept"}, ok, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (dbg_state == ST_ISSUE) begin
        saw = 1; s_in = alu_in_sel; s_out = alu_out_sel;
      end
      if (hif.res_valid) begin
        got = 1;
        break;
      end
    end
    chk({name, "_resp_seen"}, got, 1'b1);
    chk({name, "_latency"}, lat, (op == 3'd7) ? 2 : 4);
    chk({name, "_data"}, hif.res_data, ed);
    chk({name, "_err"}, hif.res_err, ee);
    chk({name, "_alu_driven"}, saw, (op != 3'd7));
    if (op != 3'd7) begin
      chk({name, "_in_sel"}, s_in, e_in);
      chk({name, "_out_sel"}, s_out, e_out);
    end
    @(posedge clk); #1;
    hif.res_ready = 1'b1;
    @(posedge clk); #1;
    hif.res_ready = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    hif.res_ready = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    hif.res_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int sent, cyc, seen_valid;
    bit acc;
    hif.cmd_valid = 0; hif.cmd_op = 0; hif.cmd_a = 0; hif.cmd_b = 0;
    hif.cmd_chain = 0; hif.res_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_one("add",   3'd4, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 3'b010, 7'b0000100);
    run_one("mul",   3'd6, 8'h20, 8'h10, 1'b0, 8'h00, 1'b1, 3'b010, 7'b0000001);
    run_one("and",   3'd0, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 3'b010, 7'b1000000);
    run_one("add23", 3'd4, 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 3'b010, 7'b0000100);
    run_one("chsub", 3'd5, 8'hAA, 8'h01, 1'b1, 8'h04, 1'b0, 3'b100, 7'b0000010);
    run_one("illeg", 3'd7, 8'h11, 8'h22, 1'b0, 8'h00, 1'b1, 3'b000, 7'b0000000);
    run_one("chadd", 3'd4, 8'h77, 8'h01, 1'b1, 8'h05, 1'b0, 3'b100, 7'b0000100);

    // FIFO fill while the response is stalled
    hif.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(3'(i), 8'(8'h10 + i), 8'(8'h31 + i), 1'b0, 10, ok);
      chk("fill_accept", ok, 1'b1);
    end
    push_cmd(3'd4, 8'h01, 8'h01, 1'b0, 6, ok);
    chk("fill_sixth_rejected", ok, 1'b0);
    chk("fill_cmd_ready_low", hif.cmd_ready, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    wait_drain(100);

    // reset in the middle of a WAIT
    push_cmd(3'd3, 8'h07, 8'h08, 1'b0, 10, ok);
    @(posedge clk);
    @(posedge clk); #1;
    chk("in_wait_before_rst", dbg_state, ST_WAIT);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (hif.res_valid) seen_valid++;
    end
    chk("no_resp_after_rst", seen_valid, 0);
    run_one("rstch", 3'd4, 8'h99, 8'h07, 1'b1, 8'h07, 1'b0, 3'b100, 7'b0000100);

    // randomized traffic
    sent = 0; cyc = 0;
    while (sent < 300 && cyc < 20000) begin
      @(negedge clk);
      acc = hif.cmd_valid && hif.cmd_ready;
      if (acc) sent++;
      @(posedge clk); #1;
      cyc++;
      hif.res_ready = ($urandom_range(0, 3) != 0);
      if (acc || !hif.cmd_valid) begin
        if (sent < 300 && $urandom_range(0, 2) != 0) begin
          hif.cmd_valid = 1'b1;
          hif.cmd_op    = 3'($urandom_range(0, 7));
          hif.cmd_a     = 8'($urandom_range(0, 255));
          hif.cmd_b     = 8'($urandom_range(0, 255));
          hif.cmd_chain = ($urandom_range(0, 3) == 0);
        end else begin
          hif.cmd_valid = 1'b0;
        end
      end
    end
    hif.cmd_valid = 1'b0;
    chk("random_all_sent", sent, 300);
    wait_drain(2000);
    chk("issue_queue_empty", iss_q.size(), 0);
`ifdef ALU_SEQ_STATS_EN
    @(negedge clk);
    chk("stat_cmds", stat_cmds, 16'(hs_cnt));
    chk("stat_errs", stat_errs, 16'(err_cnt));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command front-end for the 8-bit accumulator ALU. Buffers ALU commands (opcode plus two operands) in a small FIFO and issues them one at a time. Drives the ALU's operand, input-select and one-hot output-select lines, waits the ALU's register latency, then captures the result and overflow into a valid/ready response port. Decouples the bursty host side from the ALU's one-operation-per-issue timing.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2
ALU_LAT, 1, clock cycles from issue until ALU result is valid (ALU operand DFF stage)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO not full
cmd_op  in  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MUL, 7 illegal
cmd_a  in  8  operand A (accumulator operand)
cmd_b  in  8  operand B
cmd_chain  in  1  1 = use previous ALU result as A (persist), cmd_a ignored
alu_num1  out  8  to ALU num1
alu_num2  out  8  to ALU num2
alu_in_sel  out  3  one-hot: 3'b100 persist, 3'b010 load, 3'b001 clear
alu_out_sel  out  7  one-hot: 7'b1000000 >> op (bit6 AND ... bit0 MUL)
alu_result  in  8  ALU outputVal
alu_ovf  in  1  ALU multiply overflow
res_valid  out  1  response valid
res_ready  in  1  host accepts response
res_data  out  8  captured result
res_err  out  1  overflow on MUL, or illegal opcode

Behaviour:
- FIFO: DEPTH entries of {op, a, b, chain}; push on cmd_valid&&cmd_ready; cmd_ready = !full. Push when full is ignored. Simultaneous push and pop when full: the pop frees the slot but cmd_ready stays low that cycle; registered full flag.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE: FIFO non-empty -> pop the head entry into the cmd register. Legal op -> ISSUE. op==7 -> RESP with res_data=0 and res_err=1; the ALU is not driven.
- ISSUE (1 cycle): alu_num1=a, alu_num2=b, alu_out_sel per op, alu_in_sel = chain ? persist : load. Then go to WAIT with the latency counter set to ALU_LAT.
- WAIT: count down each cycle. At 0, capture res_data=alu_result and res_err=alu_ovf&&(op==6) -> RESP.
- RESP: res_valid=1 and held stable until res_ready. On the handshake cycle go to IDLE. With no back-to-back bypass, peak throughput is one command per ALU_LAT+3 cycles.
- Outside ISSUE: alu_in_sel=persist (3'b100) so the accumulator holds, alu_out_sel keeps the last value, and alu_num1/num2 keep their last values.
- Reset (any state, mid-operation included): FIFO emptied, FSM to IDLE, res_valid=0, res_data=0, res_err=0, alu_num1=alu_num2=0, alu_in_sel=3'b001 (clear) during the rst cycle and persist afterwards, alu_out_sel=7'b0000100 (ADD), cmd_ready=1 on the first cycle after reset. Any in-flight command is dropped with no response.
- First command after reset with chain=1: the accumulator operand is 0, because it was cleared.

Optional Feature:
Macro ALU_SEQ_STATS_EN.
- Defined: adds outputs stat_cmds[15:0] and stat_errs[15:0]. stat_cmds counts completed response handshakes. stat_errs counts handshakes with res_err=1. Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_AND..OP_MUL, OP_ILLEGAL
  - IN_SEL_PERSIST/LOAD/CLEAR encodings
  - FSM state encodings (2-bit)
  - function op_to_outsel
- One sub-module, alu_cmd_fifo: parametrised synchronous FIFO with full/empty flags, instantiated once.

Test Plan:
- Reset then cmd ADD a=8'h05 b=8'h03 -> alu_in_sel=3'b010, alu_out_sel=7'b0000100 in ISSUE; res_data=8'h08, res_err=0.
- MUL a=8'h20 b=8'h10 with the ALU model flagging overflow -> res_err=1; AND a=8'hF0 b=8'h3C -> res_data=8'h30, res_err=0.
- Chain: ADD 2+3, then chain=1 SUB b=1 -> second issue drives alu_in_sel=3'b100, res_data=8'h04.
- Push 5 commands with DEPTH=4 while res_ready=0 -> cmd_ready falls after 4 accepted (with one already popped: after 5); responses come out in order once res_ready=1, and res_data stays stable while stalled.
- op=7 -> the ALU is never driven with load; res_data=0, res_err=1, response follows IDLE directly.
- rst asserted during WAIT -> no response, res_valid=0, FIFO empty next cycle, alu_in_sel=3'b001 during the reset cycle; the next command completes normally.
